// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed or unsigned, START/BUSY/DONE handshake.
// Each quotient bit comes from a WIDTH+1-bit trial subtract (A + ~B + 1, carry = no borrow).
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] part, part_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [WIDTH-1:0] dvs, dvs_nx;
    logic             q_neg, q_neg_nx;
    logic             r_neg, r_neg_nx;
    logic             busy_nx, done_nx, dz_nx;
    logic [WIDTH-1:0] quot_nx, rem_nx;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             diff_top_unused;

    assign dvd_neg = SIGNED & DIVIDEND[WIDTH-1];
    assign dvs_neg = SIGNED & DIVISOR[WIDTH-1];

    // The dividend MSB shifts into the partial remainder while the freed LSB of
    // the work register receives the new quotient bit.
    assign shifted = {part, work[WIDTH-1]};
    assign {no_borrow, diff} = {1'b0, shifted} + {1'b0, ~{1'b0, dvs}}
                             + {{(WIDTH + 1){1'b0}}, 1'b1};
    // Top difference bit is always zero when the trial is kept.
    assign diff_top_unused = diff[WIDTH];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        part_nx  = part;
        work_nx  = work;
        dvs_nx   = dvs;
        q_neg_nx = q_neg;
        r_neg_nx = r_neg;
        busy_nx  = BUSY;
        done_nx  = 1'b0;
        dz_nx    = DIV_ZERO;
        quot_nx  = QUOTIENT;
        rem_nx   = REMAINDER;

        case (state)
            IDLE: begin
                if (START) begin
                    if (DIVISOR == '0) begin
                        quot_nx = '1;
                        rem_nx  = DIVIDEND;
                        dz_nx   = 1'b1;
                        done_nx = 1'b1;
                    end else begin
                        work_nx  = dvd_neg ? ('0 - DIVIDEND) : DIVIDEND;
                        dvs_nx   = dvs_neg ? ('0 - DIVISOR) : DIVISOR;
                        q_neg_nx = dvd_neg ^ dvs_neg;
                        r_neg_nx = dvd_neg;
                        part_nx  = '0;
                        cnt_nx   = CNT_W'(WIDTH);
                        busy_nx  = 1'b1;
                        state_nx = CALC;
                    end
                end
            end
            CALC: begin
                part_nx = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                work_nx = {work[WIDTH-2:0], no_borrow};
                cnt_nx  = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                quot_nx  = q_neg ? ('0 - work) : work;
                rem_nx   = r_neg ? ('0 - part) : part;
                dz_nx    = 1'b0;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            part      <= '0;
            work      <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DIV_ZERO  <= 1'b0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            part      <= part_nx;
            work      <= work_nx;
            dvs       <= dvs_nx;
            q_neg     <= q_neg_nx;
            r_neg     <= r_neg_nx;
            BUSY      <= busy_nx;
            DONE      <= done_nx;
            DIV_ZERO  <= dz_nx;
            QUOTIENT  <= quot_nx;
            REMAINDER <= rem_nx;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed requests push expectations, a
// negedge monitor checks every DONE for values and completion cycle.
module tb_seq_divider;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         nRESET;
    logic         START;
    logic         SIGNED;
    logic [W-1:0] DIVIDEND;
    logic [W-1:0] DIVISOR;
    logic         BUSY;
    logic         DONE;
    logic         DIV_ZERO;
    logic [W-1:0] QUOTIENT;
    logic [W-1:0] REMAINDER;

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .START    (START),
        .SIGNED   (SIGNED),
        .DIVIDEND (DIVIDEND),
        .DIVISOR  (DIVISOR),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .DIV_ZERO (DIV_ZERO),
        .QUOTIENT (QUOTIENT),
        .REMAINDER(REMAINDER)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got DONE at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("quotient", QUOTIENT, mon_e.q);
                chk("remainder", REMAINDER, mon_e.r);
                chk("div_zero", W'(DIV_ZERO), W'(mon_e.dz));
                chk("done_cycle", W'(cyc), W'(mon_e.cyc));
            end
        end
    end

    // Called between a negedge and the next posedge; that posedge samples START.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic push);
        exp_t e;
        SIGNED   = sgn;
        DIVIDEND = a;
        DIVISOR  = b;
        START    = 1'b1;
        if (push) begin
            e.q   = eq;
            e.r   = er;
            e.dz  = (b == '0);
            e.cyc = (b == '0) ? cyc + 1 : cyc + W + 2;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(output int busy);
        busy = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (i == 0) begin
                DIVIDEND = $urandom;
                DIVISOR  = $urandom;
                SIGNED   = 1'($urandom);
            end
            if (BUSY === 1'b1) busy++;
            #1;
            if (sb.size() == 0) return;
        end
        checks++;
        fails++;
        $display("FAIL timeout: got %0d pending results expected 0", sb.size());
        sb.delete();
    endtask

    task automatic run(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er);
        int bc;
        issue(sgn, a, b, eq, er, 1'b1);
        wait_idle(bc);
        chk("busy_cycles", W'(bc), (b == '0) ? W'(0) : W'(W + 1));
    endtask

    initial begin
        int bc;
        int d0;
        bit seen;
        nRESET   = 1'b0;
        START    = 1'b0;
        SIGNED   = 1'b0;
        DIVIDEND = '0;
        DIVISOR  = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", W'(BUSY), '0);
        chk("rst_done", W'(DONE), '0);
        chk("rst_div_zero", W'(DIV_ZERO), '0);
        chk("rst_quotient", QUOTIENT, '0);
        chk("rst_remainder", REMAINDER, '0);
        nRESET = 1'b1;
        @(negedge CLK);
        #1;

        run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1);
        run(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run(1'b1, 32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 32'd0);
        run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        run(1'b0, 32'd5, 32'd10, 32'd0, 32'd5);
        run(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        run(1'b1, 32'd9, 32'd3, 32'd3, 32'd0);

        // START during CALC is ignored; START in the DONE cycle is accepted.
        d0 = done_cnt;
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b1);
        repeat (10) begin
            @(negedge CLK);
            START = 1'b0;
        end
        #1;
        issue(1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 1'b0);
        @(negedge CLK);
        START = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) seen = 1'b1;
        end
        chk("handshake_done_seen", W'(seen), W'(1));
        issue(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b1);
        wait_idle(bc);
        chk("b2b_busy_cycles", W'(bc), W'(W + 1));
        chk("handshake_done_count", W'(done_cnt - d0), W'(2));

        // Reset at the tenth CALC edge aborts without DONE.
        issue(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        d0 = done_cnt;
        repeat (9) begin
            @(negedge CLK);
            START = 1'b0;
        end
        chk("hold_quotient", QUOTIENT, 32'd100);
        chk("mid_calc_busy", W'(BUSY), W'(1));
        nRESET = 1'b0;
        @(negedge CLK);
        nRESET = 1'b1;
        chk("abort_busy", W'(BUSY), '0);
        chk("abort_done", W'(DONE), '0);
        chk("abort_quotient", QUOTIENT, '0);
        chk("abort_remainder", REMAINDER, '0);
        chk("abort_div_zero", W'(DIV_ZERO), '0);
        repeat (W + 5) @(negedge CLK);
        chk("abort_no_done", W'(done_cnt - d0), '0);
        #1;
        run(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 expected finish");
        $fatal(1);
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Iterative radix-2 restoring divider for the integer datapath. It uses the inverse of the datapath add, trial subtraction, where the subtract is computed as A + ~B + 1 and carry-out means no borrow. It accepts one signed or unsigned divide request through a START/BUSY/DONE handshake and returns quotient and remainder after a fixed latency. It sits beside the ALU as a multi-cycle execution unit.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH

Ports:
CLK  input  1  rising-edge clock
nRESET  input  1  synchronous active-low reset
START  input  1  request strobe; sampled only in IDLE
SIGNED  input  1  1 = two's-complement divide, 0 = unsigned; sampled with START
DIVIDEND  input  WIDTH  numerator; sampled with START
DIVISOR  input  WIDTH  denominator; sampled with START
BUSY  output  1  high while a request is in progress
DONE  output  1  one-cycle completion pulse
DIV_ZERO  output  1  valid with DONE; divisor was zero
QUOTIENT  output  WIDTH  result; held until next completion
REMAINDER  output  WIDTH  result; held until next completion

Behaviour:
- Interface: one clock (CLK); reset nRESET is synchronous and active-low.
- Reset (nRESET=0 at a rising edge): state=IDLE; BUSY=0, DONE=0, DIV_ZERO=0, QUOTIENT=0, REMAINDER=0; counter and work registers cleared.
- Reset mid-operation aborts the request with no DONE. Results from the aborted request are never presented.
- States: IDLE, CALC, FIX.
- IDLE, START=1, DIVISOR!=0 (edge t):
  - Latch |DIVIDEND| and |DIVISOR|; absolute value applies only when SIGNED=1.
  - Latch quotient sign = sign(DIVIDEND) XOR sign(DIVISOR) and remainder sign = sign(DIVIDEND); both are 0 when SIGNED=0.
  - Partial remainder := 0; counter := WIDTH; BUSY := 1; go to CALC.
- IDLE, START=1, DIVISOR==0 (edge t):
  - Bypass. QUOTIENT := all ones; REMAINDER := DIVIDEND unmodified; DIV_ZERO := 1; DONE := 1; BUSY stays 0; remain in IDLE.
  - DONE is visible in cycle t+1.
- CALC, one bit per edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial = shifted partial remainder (WIDTH+1 bits) minus divisor.
  - If no borrow: keep trial and shift in quotient bit 1. Otherwise restore and shift in 0.
  - Counter decrements; go to FIX when it reaches 1. CALC lasts exactly WIDTH edges (t+1 to t+WIDTH).
- FIX (edge t+WIDTH+1):
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register QUOTIENT/REMAINDER; DIV_ZERO := 0; DONE := 1; BUSY := 0; go to IDLE.
- Latency: DONE is high in the cycle after edge t+WIDTH+1, i.e. WIDTH+1 edges after START is sampled. DONE is always exactly one cycle wide.
- Rounding: signed division truncates toward zero. The remainder has the sign of the dividend; a zero remainder is never negated to nonzero.
- Overflow: signed MIN / -1 gives QUOTIENT=MIN, REMAINDER=0, DIV_ZERO=0. This falls out of unsigned magnitude arithmetic with a WIDTH+1-bit trial.
- START while BUSY=1 is ignored and has no effect on operands.
- START in the same cycle DONE=1 (state already IDLE) is accepted normally. This allows back-to-back requests with no dead cycle.
- QUOTIENT/REMAINDER/DIV_ZERO change only at the completion edge or on reset.
- SIGNED, DIVIDEND and DIVISOR may change freely after the START edge.

Test Plan:
1. Unsigned, WIDTH=32: DIVIDEND=100, DIVISOR=7, START 1 cycle -> DONE 33 edges later, QUOTIENT=14, REMAINDER=2, DIV_ZERO=0; BUSY high for exactly 33 cycles.
2. Signed: -7 / 2 -> QUOTIENT=0xFFFFFFFD (-3), REMAINDER=0xFFFFFFFF (-1). Then 7 / -2 -> QUOTIENT=0xFFFFFFFD, REMAINDER=1. Unsigned 0xFFFFFFF9 / 2 -> QUOTIENT=0x7FFFFFFC, REMAINDER=1.
3. Divide by zero: DIVIDEND=0x1234, DIVISOR=0 -> DONE and DIV_ZERO next cycle, QUOTIENT=0xFFFFFFFF, REMAINDER=0x1234, BUSY never asserted.
4. Overflow: signed 0x80000000 / 0xFFFFFFFF -> QUOTIENT=0x80000000, REMAINDER=0, DIV_ZERO=0.
5. Handshake:
   - START with 50/5, then START with 9/3 pulsed mid-CALC -> only 10 r 0 is reported, and only one DONE.
   - Next START asserted during the DONE cycle is accepted; its DONE follows 33 edges later.
6. Reset: nRESET=0 for 1 cycle during CALC (edge 10) -> BUSY=0, DONE never pulses, QUOTIENT=REMAINDER=0. A following 100/7 completes correctly.
